// File: rtl/cmem_seq.sv
// Host-side sequencer for the FIR coefficient memory: streams a coefficient load into
// cmem and sweeps it back out one tap per cycle, tagged with its index.
module cmem_seq #(
  parameter int DW    = 16,
  parameter int AW    = 6,
  parameter int NTAPS = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_start_i,
  input  logic          coef_valid_i,
  input  logic [DW-1:0] coef_data_i,
  output logic          coef_ready_o,
  output logic          load_done_o,
  input  logic          run_start_i,
  output logic          tap_valid_o,
  output logic [DW-1:0] tap_data_o,
  output logic [AW-1:0] tap_idx_o,
  output logic          sweep_done_o,
  output logic          busy_o,
  output logic          loaded_o,
  output logic          cen_o,
  output logic          wen_o,
  output logic [AW-1:0] a_o,
  output logic [DW-1:0] d_o,
  input  logic [DW-1:0] q_i
);

  // state   | meaning
  // S_IDLE  | waiting for a load or sweep request
  // S_LOAD  | writing streamed coefficients to addresses 0..NTAPS-1
  // S_RUN   | issuing one read per cycle, addresses 0..NTAPS-1
  // S_DRAIN | last read's data is on Q; no access issued
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_e;

  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic          loaded_q;
  logic          load_done_q;
  logic          tap_valid_q;
  logic [AW-1:0] tap_idx_q;
  logic          sweep_done_q;
  logic          wr_en;

  assign wr_en = (state_q == S_LOAD) && coef_valid_i;
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      loaded_q     <= 1'b0;
      load_done_q  <= 1'b0;
      tap_valid_q  <= 1'b0;
      tap_idx_q    <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      load_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      // Read data arrives one cycle after the read edge, so tag it with last cycle's address
      tap_valid_q  <= (state_q == S_RUN);
      tap_idx_q    <= cnt_q;
      case (state_q)
        S_IDLE: begin
          if (load_start_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end else if (run_start_i && loaded_q) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_LOAD: begin
          if (coef_valid_i) begin
            if (cnt_q == LAST) begin
              state_q     <= S_IDLE;
              cnt_q       <= '0;
              load_done_q <= 1'b1;
              loaded_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == LAST) begin
            state_q      <= S_DRAIN;
            cnt_q        <= '0;
            sweep_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DRAIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coef_ready_o = (state_q == S_LOAD);
  assign busy_o       = (state_q != S_IDLE);
  assign cen_o        = !(wr_en || (state_q == S_RUN));
  assign wen_o        = !wr_en;
  assign a_o          = cnt_q;
  assign d_o          = coef_data_i;
  assign load_done_o  = load_done_q;
  assign loaded_o     = loaded_q;
  assign tap_valid_o  = tap_valid_q;
  assign tap_idx_o    = tap_idx_q;
  assign tap_data_o   = q_i;
  assign sweep_done_o = sweep_done_q;

endmodule
